// File: rtl/decode_stage_hs.sv
// rtl/decode_stage_hs.sv - RV32I/RV32E decode stage with handshakes, hazard stalls and early redirect
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   in_valid_i/in_ready_o        fetch-side handshake, instr_i/pc_i qualified by in_valid_i
//   wb_we_i/wb_rd_ptr_i/wb_data_i register-file write-back port
//   out_valid_o/out_ready_i      execute-side handshake for the registered bundle
//   out_pc_o ... illegal_o       decoded bundle (operands, immediate, control)
//   redirect_valid_o/redirect_pc_o one-cycle fetch restart request
//
// Optional build macro: WB_BYPASS_EN (forward same-cycle write-back data into operands).

module decode_stage_hs #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_ptr_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [XLEN-1:0] rs1_o,
  output logic [XLEN-1:0] rs2_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rd_ptr_o,
  output logic [7:0]      alu_op_o,
  output logic [6:0]      funct7_o,
  output logic            alu_src_o,
  output logic            reg_we_o,
  output logic            mem_we_o,
  output logic            mem_re_o,
  output logic [1:0]      hb_o,
  output logic            ul_o,
  output logic            illegal_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALUR   = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [7:0]      alu_op;
    logic [6:0]      funct7;
    logic            alu_src;
    logic            reg_we;
    logic            mem_we;
    logic            mem_re;
    logic [1:0]      hb;
    logic            ul;
    logic            illegal;
  } bundle_t;

  function automatic logic idx_ok(input logic [4:0] idx);
    return {27'd0, idx} < NREGS;
  endfunction

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic src_hit(input logic used, input logic [4:0] src, input logic [4:0] rd);
    return used && (src != 5'd0) && (src == rd);
  endfunction

  // ---------------------------------------------------------------- state
  bundle_t         bundle_q, bundle_d;
  logic            out_valid_q, out_valid_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  // rd of a load handed to execute last cycle; its data is not yet written back
  logic            ld_trk_valid_q, ld_trk_valid_d;
  logic [4:0]      ld_trk_rd_q, ld_trk_rd_d;

  // ---------------------------------------------------------------- register file
  logic [XLEN-1:0] rf_q [NREGS];

  always_ff @(posedge clk_i) begin
    if (wb_we_i && (wb_rd_ptr_i != 5'd0) && idx_ok(wb_rd_ptr_i)) begin
      rf_q[wb_rd_ptr_i[AW-1:0]] <= wb_data_i;
    end
  end

  // ---------------------------------------------------------------- field decode
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rs1_idx, rs2_idx, rd_idx;

  assign opcode  = instr_i[6:0];
  assign funct3  = instr_i[14:12];
  assign rs1_idx = instr_i[19:15];
  assign rs2_idx = instr_i[24:20];
  assign rd_idx  = instr_i[11:7];

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_alui, is_alur;

  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_alui   = (opcode == OP_ALUI);
  assign is_alur   = (opcode == OP_ALUR);

  logic rs1_used, rs2_used, rd_used, known_op, bad_idx, illegal;

  assign rs1_used = is_alur | is_alui | is_load | is_store | is_branch | is_jalr;
  assign rs2_used = is_alur | is_store | is_branch;
  assign rd_used  = is_alur | is_alui | is_load | is_lui | is_auipc | is_jal | is_jalr;
  assign known_op = rs1_used | rd_used;
  assign bad_idx  = (rs1_used && !idx_ok(rs1_idx)) || (rs2_used && !idx_ok(rs2_idx)) ||
                    (rd_used && !idx_ok(rd_idx));
  assign illegal  = !known_op || bad_idx;

  logic [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;

  assign imm_i32 = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u32 = {instr_i[31:12], 12'd0};
  assign imm_j32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  // ---------------------------------------------------------------- operands
  logic [XLEN-1:0] rs1_rf, rs2_rf, rs1_val, rs2_val;
  logic            wb_hit_rs1, wb_hit_rs2, wb_hazard;

  assign rs1_rf = ((rs1_idx != 5'd0) && idx_ok(rs1_idx)) ? rf_q[rs1_idx[AW-1:0]] : '0;
  assign rs2_rf = ((rs2_idx != 5'd0) && idx_ok(rs2_idx)) ? rf_q[rs2_idx[AW-1:0]] : '0;

  assign wb_hit_rs1 = wb_we_i && src_hit(rs1_used, rs1_idx, wb_rd_ptr_i);
  assign wb_hit_rs2 = wb_we_i && src_hit(rs2_used, rs2_idx, wb_rd_ptr_i);

`ifdef WB_BYPASS_EN
  assign rs1_val   = wb_hit_rs1 ? wb_data_i : rs1_rf;
  assign rs2_val   = wb_hit_rs2 ? wb_data_i : rs2_rf;
  assign wb_hazard = 1'b0;
`else
  // Without forwarding, wait one cycle so the array holds the new value.
  assign rs1_val   = rs1_rf;
  assign rs2_val   = rs2_rf;
  assign wb_hazard = wb_hit_rs1 || wb_hit_rs2;
`endif

  // ---------------------------------------------------------------- hazards / handshake
  logic ld_out_hit, ld_trk_hit, hazard, squash, accept, take_in;

  assign ld_out_hit = out_valid_q && bundle_q.mem_re &&
                      (src_hit(rs1_used, rs1_idx, bundle_q.rd) || src_hit(rs2_used, rs2_idx, bundle_q.rd));
  assign ld_trk_hit = ld_trk_valid_q &&
                      (src_hit(rs1_used, rs1_idx, ld_trk_rd_q) || src_hit(rs2_used, rs2_idx, ld_trk_rd_q));
  assign hazard     = ld_out_hit || ld_trk_hit || wb_hazard;

  // The redirect pulse cycle discards whatever fetch presents, so a hazard
  // on that wrong-path instruction must not block it.
  assign squash     = redirect_valid_q;
  assign in_ready_o = (!out_valid_q || out_ready_i) && (!hazard || squash);
  assign accept     = in_valid_i && in_ready_o;
  assign take_in    = accept && !squash;

  // ---------------------------------------------------------------- branch resolution
  logic            br_taken, redirect_req;
  logic [XLEN-1:0] redirect_tgt, jalr_sum;

  assign jalr_sum = rs1_val + sext(imm_i32);

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val <  rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  assign redirect_req = !illegal && (is_jal || is_jalr || (is_branch && br_taken));

  always_comb begin
    redirect_tgt = pc_i + sext(imm_b32);
    if (is_jal) begin
      redirect_tgt = pc_i + sext(imm_j32);
    end else if (is_jalr) begin
      redirect_tgt = {jalr_sum[XLEN-1:1], 1'b0};
    end
  end

  // ---------------------------------------------------------------- bundle decode
  bundle_t dec_bundle;

  always_comb begin
    dec_bundle         = '0;
    dec_bundle.pc      = pc_i;
    dec_bundle.rd      = rd_idx;
    dec_bundle.illegal = illegal;
    dec_bundle.alu_op  = 8'h01;
    dec_bundle.rs1     = rs1_val;
    dec_bundle.rs2     = rs2_used ? rs2_val : '0;

    if (is_jal || is_jalr || is_auipc) begin
      dec_bundle.rs1 = pc_i;
    end else if (is_lui) begin
      dec_bundle.rs1 = '0;
    end

    if (is_alui || is_load || is_jalr) begin
      dec_bundle.imm = sext(imm_i32);
    end
    if (is_store) dec_bundle.imm = sext(imm_s32);
    if (is_branch) dec_bundle.imm = sext(imm_b32);
    if (is_lui || is_auipc) dec_bundle.imm = sext(imm_u32);
    // Link value is pc + 4 computed by execute's adder.
    if (is_jal || is_jalr) dec_bundle.imm = XLEN'(4);

    if (is_alur || is_alui) begin
      dec_bundle.alu_op = 8'h01 << funct3;
    end
    if (is_alur || (is_alui && funct3 == 3'b101)) begin
      dec_bundle.funct7 = instr_i[31:25];
    end

    dec_bundle.alu_src = is_alui | is_load | is_store | is_lui | is_auipc | is_jal | is_jalr;
    dec_bundle.reg_we  = rd_used && (rd_idx != 5'd0) && !illegal;
    dec_bundle.mem_we  = is_store && !illegal;
    dec_bundle.mem_re  = is_load && !illegal;

    if (is_load || is_store) begin
      dec_bundle.hb = funct3[1:0];
      dec_bundle.ul = funct3[2];
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (take_in) begin
      out_valid_d = 1'b1;
      bundle_d    = dec_bundle;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end

    redirect_valid_d = take_in && redirect_req;
    redirect_pc_d    = (take_in && redirect_req) ? redirect_tgt : redirect_pc_q;

    ld_trk_valid_d = out_valid_q && out_ready_i && bundle_q.mem_re;
    ld_trk_rd_d    = bundle_q.rd;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bundle_q         <= '0;
      bundle_q.pc      <= RESET_PC;
      out_valid_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= RESET_PC;
      ld_trk_valid_q   <= 1'b0;
      ld_trk_rd_q      <= 5'd0;
    end else begin
      bundle_q         <= bundle_d;
      out_valid_q      <= out_valid_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      ld_trk_valid_q   <= ld_trk_valid_d;
      ld_trk_rd_q      <= ld_trk_rd_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign out_valid_o      = out_valid_q;
  assign out_pc_o         = bundle_q.pc;
  assign rs1_o            = bundle_q.rs1;
  assign rs2_o            = bundle_q.rs2;
  assign imm_o            = bundle_q.imm;
  assign rd_ptr_o         = bundle_q.rd;
  assign alu_op_o         = bundle_q.alu_op;
  assign funct7_o         = bundle_q.funct7;
  assign alu_src_o        = bundle_q.alu_src;
  assign reg_we_o         = bundle_q.reg_we;
  assign mem_we_o         = bundle_q.mem_we;
  assign mem_re_o         = bundle_q.mem_re;
  assign hb_o             = bundle_q.hb;
  assign ul_o             = bundle_q.ul;
  assign illegal_o        = bundle_q.illegal;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: doc/decode_stage_hs.md
Name: decode_stage_hs

Overview:
- Parametrised successor of the single-cycle decode stage: decodes RV32I (or RV32E) instructions into a registered bundle for the execute stage.
- Adds valid/ready handshakes on both sides, load-use hazard stalls, JALR support, early branch/jump redirect with one-slot wrong-path squash, and illegal-instruction flagging.
- Sits between fetch and execute and owns the architectural register file.

Parameters:
XLEN, 32, datapath width of operands, immediates and PCs
NREGS, 32, register count; 32 = RV32I, 16 = RV32E (register index bit 4 set = illegal)
RESET_PC, 0, value of out_pc_o and redirect_pc_o after reset

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
in_valid_i  in  1  fetch presents instr_i/pc_i
in_ready_o  out  1  stage accepts the instruction this cycle
instr_i  in  32  instruction word
pc_i  in  XLEN  address of instr_i
wb_we_i  in  1  write-back enable
wb_rd_ptr_i  in  5  write-back register index
wb_data_i  in  XLEN  write-back data
out_valid_o  out  1  bundle valid
out_ready_i  in  1  execute accepts bundle
out_pc_o  out  XLEN  PC of bundle
rs1_o  out  XLEN  operand 1 (PC for JAL/AUIPC/JALR link, 0 for LUI)
rs2_o  out  XLEN  operand 2
imm_o  out  XLEN  immediate (4 for JAL/JALR)
rd_ptr_o  out  5  destination register
alu_op_o  out  8  one-hot funct3 for ALU-R/ALU-I; ADD (8'h01) otherwise
funct7_o  out  7  funct7 for ALU-R and for SRAI/SRLI; 0 otherwise
alu_src_o  out  1  1 = use imm_o
reg_we_o  out  1  write rd (forced 0 when rd = x0)
mem_we_o  out  1  store
mem_re_o  out  1  load
hb_o  out  2  funct3[1:0] for memory width
ul_o  out  1  funct3[2]: unsigned load
illegal_o  out  1  unknown opcode or out-of-range register index
redirect_valid_o  out  1  one-cycle pulse: fetch must restart at redirect_pc_o
redirect_pc_o  out  XLEN  redirect target

Behaviour:
- Reset: all outputs 0 except out_pc_o and redirect_pc_o, which go to RESET_PC. Hazard and squash state cleared. Register contents are not reset; x0 always reads 0. Reset overrides any stall or handshake in progress.
- Accept: instruction is accepted when in_valid_i && in_ready_o.
- in_ready_o = (!out_valid_o || out_ready_i) && !hazard.
- Latency: accepted instruction appears on the bundle next cycle with out_valid_o = 1.
- Backpressure: bundle is held stable while out_valid_o && !out_ready_i.
- Register usage:
  - rs1 used by ALU-R, ALU-I, LOAD, STORE, BRANCH, JALR.
  - rs2 used by ALU-R, STORE, BRANCH.
- Load-use hazard: asserted when a used, nonzero source equals the rd of a load that is either (a) in the output register, or (b) handed to execute in the previous cycle (one-cycle tracking register). While the hazard holds, in_ready_o = 0 and no bubble is issued downstream.
- Branch resolution: compared in decode on register values, signed (BLT/BGE) and unsigned (BLTU/BGEU). Targets:
  - taken branch: pc_i + IMM_B
  - JAL: pc_i + IMM_J
  - JALR: (rs1 + IMM_I) & ~1
- Redirect: on accept of a taken branch, JAL or JALR, redirect_valid_o pulses in the next cycle with the target. The instruction accepted in that pulse cycle is consumed and discarded (out_valid_o stays 0).
- Branches set reg_we_o = 0. JAL/JALR produce a link via rs1_o = pc, imm_o = 4, alu_op ADD.
- Illegal: sets illegal_o = 1 and forces reg_we_o, mem_we_o, mem_re_o to 0; no redirect.
- Write-back occurs on the rising clock edge when wb_we_i is set and wb_rd_ptr_i != 0. A write to an index >= NREGS is ignored.
- Simultaneous redirect pulse and hazard: squash takes priority, and the hazard is re-evaluated on the next instruction.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: a same-cycle write-back whose wb_rd_ptr_i matches a used source supplies wb_data_i directly to the operand and the branch compare; no stall.
- Undefined: such a match is a hazard (in_ready_o = 0 for one cycle); the instruction is decoded next cycle with the updated register value.

Test Plan:
- ADDI x1,x0,5 (0x00500093) accepted at pc 0 -> next cycle out_valid_o = 1, rd_ptr_o = 1, imm_o = 5, alu_op_o = 8'h01, alu_src_o = 1, reg_we_o = 1.
- BEQ x0,x0,+8 (0x00000463) at pc 0x10, then any instruction -> redirect_valid_o = 1 for exactly one cycle with redirect_pc_o = 0x18; the following instruction is consumed with out_valid_o staying 0.
- LW x2,0(x0) (0x00002103) followed by ADD x3,x2,x2 (0x002101B3), out_ready_i = 1 -> in_ready_o = 0 for 2 cycles, ADD issued on the 3rd cycle.
- out_ready_i held 0 for 3 cycles with a valid bundle -> all outputs stable, in_ready_o = 0; resumes in the cycle out_ready_i returns to 1.
- Write-back x5 = 0xDEADBEEF in the same cycle as accepting ADD x6,x5,x0 (0x00028333):
  - With WB_BYPASS_EN: rs1_o = 0xDEADBEEF with no stall.
  - Without WB_BYPASS_EN: one stall cycle, then rs1_o = 0xDEADBEEF.
- Opcode 0x0000007F -> illegal_o = 1, reg_we_o = mem_we_o = mem_re_o = 0. Assert rst_i during a load-use stall -> next cycle out_valid_o = 0, redirect_valid_o = 0, in_ready_o = 1.
